glb_proc_arbiter: RTL

Round-robin arbiter that shares the global buffer processor port (proc_wr_* / proc_rd_*) between NUM_REQ independent requesters, such as the host DMA, test loaders and debug readback. It issues at most one write or read to the global buffer per cycle. It tracks outstanding reads in issue order and routes each returned read word back to the requester that issued it. It sits directly in front of global_buffer's processor interface.

---
 rtl/glb_proc_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/glb_proc_arbiter.sv
// rtl/glb_proc_arbiter.sv - round-robin arbiter sharing the global buffer processor port
// Issues at most one read or write per cycle; in-order read returns are routed back via a tag FIFO.
module glb_proc_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int ADDR_WIDTH      = 20,
  parameter int DATA_WIDTH      = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  output logic [NUM_REQ-1:0]                   req_ready,
  input  logic [NUM_REQ-1:0]                   req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        req_wr_data,
  input  logic [NUM_REQ*(DATA_WIDTH/8)-1:0]    req_wr_strb,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [DATA_WIDTH-1:0]                rsp_data,
  output logic                                 proc_wr_en,
  output logic [DATA_WIDTH/8-1:0]              proc_wr_strb,
  output logic [ADDR_WIDTH-1:0]                proc_wr_addr,
  output logic [DATA_WIDTH-1:0]                proc_wr_data,
  output logic                                 proc_rd_en,
  output logic [ADDR_WIDTH-1:0]                proc_rd_addr,
  input  logic [DATA_WIDTH-1:0]                proc_rd_data,
  input  logic                                 proc_rd_data_valid,
  output logic [$clog2(MAX_OUTSTANDING):0]     rd_outstanding,
  output logic                                 err_unexpected_rsp
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W      = $clog2(NUM_REQ);
  localparam int TAG_PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W      = TAG_PTR_W + 1;

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      tag_mem_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]      tag_mem_d [MAX_OUTSTANDING];
  logic [TAG_PTR_W-1:0]  tag_wr_ptr_q, tag_wr_ptr_d;
  logic [TAG_PTR_W-1:0]  tag_rd_ptr_q, tag_rd_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic                  wr_en_q, wr_en_d;
  logic [STRB_WIDTH-1:0] wr_strb_q, wr_strb_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  fifo_full;
  logic [NUM_REQ-1:0]    eligible;
  logic                  grant_found;
  logic [IDX_W-1:0]      grant_idx;
  logic [IDX_W:0]        rr_sum;
  logic [IDX_W-1:0]      rr_idx;
  logic                  grant_wr;
  logic                  push;
  logic                  pop;
  logic [IDX_W-1:0]      head_idx;

  // Eligibility looks only at the registered count, so the global buffer
  // return never reaches req_ready combinationally.
  always_comb begin
    fifo_full   = (cnt_q == CNT_W'(MAX_OUTSTANDING));
    eligible    = req_valid & (req_wr | {NUM_REQ{~fifo_full}});
    grant_found = 1'b0;
    grant_idx   = '0;
    rr_sum      = '0;
    rr_idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[IDX_W-1:0];
      if (!grant_found && eligible[rr_idx]) begin
        grant_found = 1'b1;
        grant_idx   = rr_idx;
      end
    end
    req_ready = '0;
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    grant_wr = req_wr[grant_idx];
    push     = grant_found && !grant_wr;
    pop      = proc_rd_data_valid && (cnt_q != '0);
    head_idx = tag_mem_q[tag_rd_ptr_q];

    ptr_d = ptr_q;
    if (grant_found) begin
      ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    wr_en_d   = grant_found && grant_wr;
    rd_en_d   = push;
    wr_strb_d = wr_strb_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    if (grant_found && grant_wr) begin
      wr_strb_d = req_wr_strb[int'(grant_idx)*STRB_WIDTH +: STRB_WIDTH];
      wr_addr_d = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_d = req_wr_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
    end
    if (push) begin
      rd_addr_d = req_addr[int'(grant_idx)*ADDR_WIDTH +: ADDR_WIDTH];
    end

    tag_mem_d    = tag_mem_q;
    tag_wr_ptr_d = tag_wr_ptr_q;
    tag_rd_ptr_d = tag_rd_ptr_q;
    if (push) begin
      tag_mem_d[tag_wr_ptr_q] = grant_idx;
      tag_wr_ptr_d            = tag_wr_ptr_q + 1'b1;
    end
    if (pop) begin
      tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    err_d = err_q || (proc_rd_data_valid && (cnt_q == '0));

    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (pop) begin
      rsp_valid_d[head_idx] = 1'b1;
      rsp_data_d            = proc_rd_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      tag_mem_q    <= '{default: '0};
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_strb_q    <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      tag_mem_q    <= tag_mem_d;
      tag_wr_ptr_q <= tag_wr_ptr_d;
      tag_rd_ptr_q <= tag_rd_ptr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      wr_en_q      <= wr_en_d;
      wr_strb_q    <= wr_strb_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign proc_wr_en         = wr_en_q;
  assign proc_wr_strb       = wr_strb_q;
  assign proc_wr_addr       = wr_addr_q;
  assign proc_wr_data       = wr_data_q;
  assign proc_rd_en         = rd_en_q;
  assign proc_rd_addr       = rd_addr_q;
  assign rsp_valid          = rsp_valid_q;
  assign rsp_data           = rsp_data_q;
  assign rd_outstanding     = cnt_q;
  assign err_unexpected_rsp = err_q;

endmodule
